// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's fetch/data ports and mem_responder.
// The core drives requests (master); the responder returns ack/err/rdata (slave).
interface mem_responder_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_we, d_addr, d_size, d_unsigned, d_wdata,
    input  d_ack, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_size, d_unsigned, d_wdata,
    output d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-ported word memory serving fetch and data channels with fixed latency,
// round-robin arbitration, load extension, store lane merging and alignment checks.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        last_d_q;
  logic        gnt_d_q, we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic        i_ack_q, d_ack_q, i_err_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;

  logic [3:0][7:0] mem_q [DEPTH_WORDS];

  logic          any_req, pick_d;
  logic          cur_d, cur_we, cur_uns;
  logic [1:0]    cur_size;
  logic [31:0]   cur_addr, cur_wdata;
  logic          enter_resp, misal, mem_we;
  logic [AW-1:0] idx;
  logic [1:0]    boff;
  logic [31:0]   rd_word, ld_data, wrep;
  logic [3:0]    be;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          unused_addr;

  assign any_req = bus.i_req | bus.d_req;
  // Data wins a tie unless it was the last channel granted.
  assign pick_d  = bus.d_req & (~bus.i_req | ~last_d_q);

  // In IDLE the live winner is used so a single-cycle latency can act on the accept edge.
  always_comb begin
    cur_d     = gnt_d_q;
    cur_we    = we_q;
    cur_uns   = uns_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_d     = pick_d;
      cur_we    = pick_d & bus.d_we;
      cur_uns   = pick_d & bus.d_unsigned;
      cur_size  = pick_d ? bus.d_size : 2'b10;
      cur_addr  = pick_d ? bus.d_addr : bus.i_addr;
      cur_wdata = bus.d_wdata;
    end
  end

  assign enter_resp = ((state_q == IDLE) && any_req && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));

  assign idx         = cur_addr[AW+1:2];
  assign boff        = cur_addr[1:0];
  assign unused_addr = ^cur_addr[31:AW+2];
  assign rd_word     = mem_q[idx];

  always_comb begin
    case (cur_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = boff[0];
      2'b10:   misal = (boff != 2'b00);
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = rd_word[8*boff +: 8];
    ld_half = boff[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_size)
      2'b00:   ld_data = {{24{~cur_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~cur_uns & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (cur_size)
      2'b00:   begin be = 4'b0001 << boff;                   wrep = {4{cur_wdata[7:0]}};  end
      2'b01:   begin be = boff[1] ? 4'b1100 : 4'b0011;       wrep = {2{cur_wdata[15:0]}}; end
      default: begin be = 4'b1111;                           wrep = cur_wdata;            end
    endcase
  end

  assign mem_we = enter_resp & cur_we & ~misal;

  // Reset has priority over a store landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][b] <= wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      if (enter_resp) begin
        if (cur_d) begin
          d_ack_q   <= 1'b1;
          d_err_q   <= misal;
          d_rdata_q <= (misal | cur_we) ? 32'd0 : ld_data;
        end else begin
          i_ack_q   <= 1'b1;
          i_err_q   <= misal;
          i_rdata_q <= misal ? 32'd0 : rd_word;
        end
      end
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_d_q  <= pick_d;
            last_d_q <= pick_d;
            we_q     <= cur_we;
            uns_q    <= cur_uns;
            size_q   <= cur_size;
            addr_q   <= cur_addr;
            wdata_q  <= cur_wdata;
            if (LATENCY == 1) begin
              state_q <= RESP;
              cnt_q   <= '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = d_rdata_q;
endmodule
